// File: rtl/dma_copy_engine.sv
// Byte-serial RAM-to-RAM copy engine: copies length bytes from src_addr to dst_addr.
// Optional macro CHECKSUM_EN adds a running modulo-2**DATA_WIDTH checksum output.
module dma_copy_engine #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_src_ptr;
    logic [ADDR_WIDTH-1:0] r_dst_ptr;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_data;

    wire w_accept = (r_state == S_IDLE) && start;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_src_ptr <= '0;
            r_dst_ptr <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src_ptr <= src_addr;
                        r_dst_ptr <= dst_addr;
                        r_cnt     <= length;
                        r_state   <= (length != '0) ? S_READ : S_DONE;
                    end
                end
                S_READ: begin
                    r_data    <= mem_rdata;
                    r_src_ptr <= r_src_ptr + 1'b1;
                    r_state   <= S_WRITE;
                end
                S_WRITE: begin
                    r_dst_ptr <= r_dst_ptr + 1'b1;
                    r_cnt     <= r_cnt - 1'b1;
                    r_state   <= (r_cnt == ADDR_WIDTH'(1)) ? S_DONE : S_READ;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: outputs decode straight from r_state, so an asynchronous reset
    // drops mem_we in the same instant without waiting for a clock edge.
    assign busy      = (r_state == S_READ) || (r_state == S_WRITE);
    assign done      = (r_state == S_DONE);
    assign mem_we    = (r_state == S_WRITE);
    assign mem_addr  = (r_state == S_READ)  ? r_src_ptr :
                       (r_state == S_WRITE) ? r_dst_ptr : '0;
    assign mem_wdata = (r_state == S_WRITE) ? r_data : '0;

`ifdef CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= '0;
        end else if (r_state == S_WRITE) begin
            r_checksum <= r_checksum + r_data;
        end
    end

    assign checksum = r_checksum;
`else
    wire w_unused_accept = w_accept;
`endif

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed testbench for dma_copy_engine with a behavioural single-port RAM.
// Define CHECKSUM_EN for both files to exercise the checksum output.
module tb_dma_copy_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [7:0] length;
    logic       busy;
    logic       done;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
`ifdef CHECKSUM_EN
    logic [7:0] checksum;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ram [0:255];

    dma_copy_engine #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    // Pulse start for one edge; returns at the negedge of cycle 1.
    task automatic do_start(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; length = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the cycle in which done is seen and the number of write cycles before it.
    task automatic wait_done(output int cyc, output int wes);
        cyc = 1;
        wes = 0;
        while (!done && cyc < 100) begin
            if (mem_we) wes++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
        #12;
        n_tests++;
        if ({busy, done, mem_we, mem_addr, mem_wdata} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b we=%b addr=%h wdata=%h, want all 0",
                     busy, done, mem_we, mem_addr, mem_wdata);
        end
`ifdef CHECKSUM_EN
        n_tests++;
        if (checksum !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_checksum: got %h, want 00", checksum);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_copy;
        logic [7:0] exp [4];
        int cyc, wes;
        exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) begin
            ram[8'h10 + i] = exp[i];
            ram[8'h80 + i] = 8'h00;
        end
        do_start(8'h10, 8'h80, 8'h04);
        wait_done(cyc, wes);
        n_tests++;
        if (cyc !== 9) begin
            n_fail++;
            $display("FAIL basic_done_cycle: got %0d, want 9", cyc);
        end
        n_tests++;
        if (wes !== 4) begin
            n_fail++;
            $display("FAIL basic_we_count: got %0d, want 4", wes);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse_width: done still %b one cycle later, want 0", done);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (ram[8'h80 + i] !== exp[i]) begin
                n_fail++;
                $display("FAIL basic_data[%0d]: got %h, want %h", i, ram[8'h80 + i], exp[i]);
            end
        end
    endtask

    task automatic test_zero_length;
        ram[8'h33] = 8'h5A;
        do_start(8'h30, 8'h33, 8'h00);
        n_tests++;
        if ({done, busy, mem_we} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_cycle1: got done=%b busy=%b we=%b, want 1 0 0", done, busy, mem_we);
        end
        @(negedge clk);
        n_tests++;
        if ({done, busy, mem_we} !== 3'b000) begin
            n_fail++;
            $display("FAIL zero_cycle2: got done=%b busy=%b we=%b, want 0 0 0", done, busy, mem_we);
        end
        n_tests++;
        if (ram[8'h33] !== 8'h5A) begin
            n_fail++;
            $display("FAIL zero_ram_unchanged: got %h, want 5a", ram[8'h33]);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] exp_rd [4];
        logic [7:0] exp_d  [4];
        logic [7:0] rd_log [8];
        int nr, cyc;
        exp_rd = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        exp_d  = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            ram[exp_rd[i]]  = exp_d[i];
            ram[8'h40 + i]  = 8'h00;
        end
        do_start(8'hFE, 8'h40, 8'h04);
        nr = 0;
        cyc = 1;
        while (!done && cyc < 50) begin
            if (busy && !mem_we && nr < 8) begin
                rd_log[nr] = mem_addr;
                nr++;
            end
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (nr !== 4) begin
            n_fail++;
            $display("FAIL wrap_read_count: got %0d, want 4", nr);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (i >= nr || rd_log[i] !== exp_rd[i]) begin
                n_fail++;
                $display("FAIL wrap_read_addr[%0d]: got %h, want %h", i, (i < nr) ? rd_log[i] : 8'hxx, exp_rd[i]);
            end
            n_tests++;
            if (ram[8'h40 + i] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL wrap_data[%0d]: got %h, want %h", i, ram[8'h40 + i], exp_d[i]);
            end
        end
    endtask

    task automatic test_start_while_busy;
        int ndone, first;
        ram[8'h20] = 8'h05; ram[8'h21] = 8'h06; ram[8'h22] = 8'h07;
        ram[8'h90] = 8'h00; ram[8'h91] = 8'h00; ram[8'h92] = 8'h00;
        ram[8'hA0] = 8'hEE;
        do_start(8'h20, 8'h90, 8'h03);
        @(negedge clk);
        start = 1'b1; src_addr = 8'h30; dst_addr = 8'hA0; length = 8'h05;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        first = 0;
        for (int c = 3; c <= 20; c++) begin
            if (done) begin
                ndone++;
                if (first == 0) first = c;
            end
            @(negedge clk);
        end
        n_tests++;
        if (ndone !== 1 || first !== 7) begin
            n_fail++;
            $display("FAIL busy_start_done: got %0d pulses first at cycle %0d, want 1 at cycle 7", ndone, first);
        end
        n_tests++;
        if ({ram[8'h90], ram[8'h91], ram[8'h92]} !== 24'h050607) begin
            n_fail++;
            $display("FAIL busy_start_data: got %h%h%h, want 050607", ram[8'h90], ram[8'h91], ram[8'h92]);
        end
        n_tests++;
        if (ram[8'hA0] !== 8'hEE) begin
            n_fail++;
            $display("FAIL busy_start_second_dst: got %h, want ee", ram[8'hA0]);
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0] dseq, bseq;
        ram[8'h50] = 8'h9C;
        ram[8'h60] = 8'h00;
        @(negedge clk);
        start = 1'b1; src_addr = 8'h50; dst_addr = 8'h60; length = 8'h01;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            dseq[c-1] = done;
            bseq[c-1] = busy;
        end
        start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (dseq !== 7'b1000100) begin
            n_fail++;
            $display("FAIL b2b_done_seq: got %b, want 1000100", dseq);
        end
        n_tests++;
        if (bseq !== 7'b0110011) begin
            n_fail++;
            $display("FAIL b2b_busy_seq: got %b, want 0110011", bseq);
        end
        n_tests++;
        if (busy !== 1'b0 || ram[8'h60] !== 8'h9C) begin
            n_fail++;
            $display("FAIL b2b_final: got busy=%b data=%h, want 0 9c", busy, ram[8'h60]);
        end
    endtask

    task automatic test_reset_mid_copy;
        int ndone;
        for (int i = 0; i < 4; i++) begin
            ram[8'h70 + i] = 8'hC0 + 8'(i);
            ram[8'hB0 + i] = 8'hEE;
        end
        do_start(8'h70, 8'hB0, 8'h04);
        // Advance to cycle 6: the write cycle after two bytes have landed.
        repeat (5) @(negedge clk);
        n_tests++;
        if (mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_precondition: got we=%b, want 1", mem_we);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (mem_we !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async_drop: got we=%b busy=%b, want 0 0", mem_we, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        n_tests++;
        if (ndone !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_no_done: got %0d active cycles, want 0", ndone);
        end
        n_tests++;
        if ({ram[8'hB0], ram[8'hB1], ram[8'hB2], ram[8'hB3]} !== 32'hC0C1EEEE) begin
            n_fail++;
            $display("FAIL rst_mid_data: got %h%h%h%h, want c0c1eeee",
                     ram[8'hB0], ram[8'hB1], ram[8'hB2], ram[8'hB3]);
        end
    endtask

`ifdef CHECKSUM_EN
    task automatic test_checksum;
        int cyc, wes;
        ram[8'hC0] = 8'h01; ram[8'hC1] = 8'h02; ram[8'hC2] = 8'hFF;
        do_start(8'hC0, 8'hD0, 8'h03);
        wait_done(cyc, wes);
        n_tests++;
        if (cyc !== 7 || checksum !== 8'h02) begin
            n_fail++;
            $display("FAIL csum_at_done: got cycle %0d sum %h, want 7 02", cyc, checksum);
        end
        @(negedge clk);
        n_tests++;
        if (checksum !== 8'h02) begin
            n_fail++;
            $display("FAIL csum_hold: got %h, want 02", checksum);
        end
        do_start(8'hC0, 8'hD8, 8'h02);
        n_tests++;
        if (checksum !== 8'h00) begin
            n_fail++;
            $display("FAIL csum_clear_on_start: got %h, want 00", checksum);
        end
        wait_done(cyc, wes);
        n_tests++;
        if (checksum !== 8'h03) begin
            n_fail++;
            $display("FAIL csum_second: got %h, want 03", checksum);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_copy();
        test_zero_length();
        test_wrap();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_copy();
`ifdef CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
